// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the shared instruction-memory read port.
// Bounded-burst grant selection, fixed-latency in-flight tag pipe, per-requester response steering.
module imem_port_arbiter #(
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [31:0]           rdata0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [31:0]           rdata1,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_q
);

  localparam logic [3:0] BURST = 4'(MAX_BURST);

  logic                    last;
  logic                    last_nxt;
  logic [3:0]              run;
  logic [3:0]              run_nxt;
  logic                    gnt_any;
  logic                    gnt_id;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_sel;
  logic [READ_LATENCY-1:0] pipe_v;
  logic [READ_LATENCY-1:0] pipe_id;

  always_comb begin
    gnt_any  = 1'b0;
    gnt_id   = last;
    last_nxt = last;
    run_nxt  = run;
    if (!rst) begin
      if (req0 && req1) begin
        gnt_any = 1'b1;
        gnt_id  = (run < BURST) ? last : ~last;
      end else if (req0) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1) begin
        gnt_any = 1'b1;
        gnt_id  = 1'b1;
      end
    end
    if (gnt_any) begin
      last_nxt = gnt_id;
      if (gnt_id == last) begin
        run_nxt = (run >= BURST) ? BURST : run + 4'd1;
      end else begin
        run_nxt = 4'd1;
      end
    end else begin
      run_nxt = 4'd0;
    end
  end

  assign addr_sel = gnt_id ? addr1 : addr0;
  assign gnt0     = gnt_any && !gnt_id;
  assign gnt1     = gnt_any && gnt_id;
  // Between grants the port keeps presenting the last granted address.
  assign mem_addr = rst ? '0 : (gnt_any ? addr_sel : addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= 1'b0;
      run     <= 4'd0;
      addr_q  <= '0;
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      last       <= last_nxt;
      run        <= run_nxt;
      pipe_v[0]  <= gnt_any;
      pipe_id[0] <= gnt_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
      if (gnt_any) begin
        addr_q <= addr_sel;
      end
    end
  end

  assign rvalid0 = !rst && pipe_v[READ_LATENCY-1] && !pipe_id[READ_LATENCY-1];
  assign rvalid1 = !rst && pipe_v[READ_LATENCY-1] && pipe_id[READ_LATENCY-1];
  assign rdata0  = mem_q;
  assign rdata1  = mem_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: three instances (RL1/MB4, RL3/MB4, RL1/MB1),
// each with a memory model returning addr + 0x1000 after READ_LATENCY cycles.
module tb_imem_port_arbiter;

  logic        clk;
  logic        rst_v    [3];
  logic        req0_v   [3];
  logic        req1_v   [3];
  logic [12:0] addr0_v  [3];
  logic [12:0] addr1_v  [3];
  logic        gnt0_v   [3];
  logic        gnt1_v   [3];
  logic        rvalid0_v[3];
  logic        rvalid1_v[3];
  logic [31:0] rdata0_v [3];
  logic [31:0] rdata1_v [3];
  logic [12:0] maddr_v  [3];
  logic [31:0] mq_v     [3];
  logic [12:0] mp       [3][3];

  int vectors;
  int miscompares;
  int step_no;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 1) ? 3 : 1;
    localparam int MB = (g == 2) ? 1 : 4;

    imem_port_arbiter #(.ADDR_WIDTH(13), .READ_LATENCY(RL), .MAX_BURST(MB)) u_dut (
      .clk     (clk),
      .rst     (rst_v[g]),
      .req0    (req0_v[g]),
      .addr0   (addr0_v[g]),
      .gnt0    (gnt0_v[g]),
      .rvalid0 (rvalid0_v[g]),
      .rdata0  (rdata0_v[g]),
      .req1    (req1_v[g]),
      .addr1   (addr1_v[g]),
      .gnt1    (gnt1_v[g]),
      .rvalid1 (rvalid1_v[g]),
      .rdata1  (rdata1_v[g]),
      .mem_addr(maddr_v[g]),
      .mem_q   (mq_v[g])
    );

    always @(posedge clk) begin
      mp[g][0] <= maddr_v[g];
      mp[g][1] <= mp[g][0];
      mp[g][2] <= mp[g][1];
    end
    assign mq_v[g] = {19'h0, mp[g][RL-1]} + 32'h1000;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s inst%0d step%0d observed=%h expected=%h", tag, k, step_no, obs, exp);
    end
  endtask

  // eg/ev are {requester1, requester0}; ed is the data expected on the valid response.
  task automatic step(input int k, input logic rs, input logic r0, input logic r1,
                      input logic [12:0] a0, input logic [12:0] a1,
                      input logic [1:0] eg, input logic [1:0] ev,
                      input logic [31:0] ed, input logic [12:0] ema);
    @(negedge clk);
    step_no++;
    rst_v[k]   = rs;
    req0_v[k]  = r0;
    req1_v[k]  = r1;
    addr0_v[k] = a0;
    addr1_v[k] = a1;
    #4;
    chk("gnt", k, {30'h0, gnt1_v[k], gnt0_v[k]}, {30'h0, eg});
    chk("rvalid", k, {30'h0, rvalid1_v[k], rvalid0_v[k]}, {30'h0, ev});
    chk("mem_addr", k, {19'h0, maddr_v[k]}, {19'h0, ema});
    if (ev == 2'b01) chk("rdata0", k, rdata0_v[k], ed);
    if (ev == 2'b10) chk("rdata1", k, rdata1_v[k], ed);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    step_no     = 0;
    for (int i = 0; i < 3; i++) begin
      rst_v[i]   = 1'b1;
      req0_v[i]  = 1'b0;
      req1_v[i]  = 1'b0;
      addr0_v[i] = 13'h0;
      addr1_v[i] = 13'h0;
    end

    // reset held with both requesting
    step(0, 1, 1, 1, 13'h005, 13'h006, 2'b00, 2'b00, 32'h0, 13'h000);
    step(0, 1, 1, 1, 13'h005, 13'h006, 2'b00, 2'b00, 32'h0, 13'h000);
    step(0, 1, 1, 1, 13'h005, 13'h006, 2'b00, 2'b00, 32'h0, 13'h000);

    // single requester, latency 1
    step(0, 0, 1, 0, 13'h000, 13'h000, 2'b01, 2'b00, 32'h0,    13'h000);
    step(0, 0, 1, 0, 13'h001, 13'h000, 2'b01, 2'b01, 32'h1000, 13'h001);
    step(0, 0, 1, 0, 13'h002, 13'h000, 2'b01, 2'b01, 32'h1001, 13'h002);
    step(0, 0, 1, 0, 13'h003, 13'h000, 2'b01, 2'b01, 32'h1002, 13'h003);
    step(0, 0, 0, 0, 13'h004, 13'h000, 2'b00, 2'b01, 32'h1003, 13'h003);
    step(0, 0, 0, 0, 13'h004, 13'h000, 2'b00, 2'b00, 32'h0,    13'h003);

    // contention from reset, burst 4
    step(0, 1, 1, 1, 13'h010, 13'h020, 2'b00, 2'b00, 32'h0,    13'h000);
    step(0, 0, 1, 1, 13'h010, 13'h020, 2'b01, 2'b00, 32'h0,    13'h010);
    step(0, 0, 1, 1, 13'h011, 13'h020, 2'b01, 2'b01, 32'h1010, 13'h011);
    step(0, 0, 1, 1, 13'h012, 13'h020, 2'b01, 2'b01, 32'h1011, 13'h012);
    step(0, 0, 1, 1, 13'h013, 13'h020, 2'b01, 2'b01, 32'h1012, 13'h013);
    step(0, 0, 1, 1, 13'h014, 13'h020, 2'b10, 2'b01, 32'h1013, 13'h020);
    step(0, 0, 1, 1, 13'h014, 13'h021, 2'b10, 2'b10, 32'h1020, 13'h021);
    step(0, 0, 1, 1, 13'h014, 13'h022, 2'b10, 2'b10, 32'h1021, 13'h022);
    step(0, 0, 1, 1, 13'h014, 13'h023, 2'b10, 2'b10, 32'h1022, 13'h023);
    step(0, 0, 1, 1, 13'h014, 13'h024, 2'b01, 2'b10, 32'h1023, 13'h014);
    step(0, 0, 1, 1, 13'h015, 13'h024, 2'b01, 2'b01, 32'h1014, 13'h015);
    step(0, 0, 0, 0, 13'h016, 13'h024, 2'b00, 2'b01, 32'h1015, 13'h015);

    // idle cycle resets the run count, latency 1
    step(0, 0, 0, 1, 13'h040, 13'h030, 2'b10, 2'b00, 32'h0,    13'h030);
    step(0, 0, 0, 1, 13'h040, 13'h031, 2'b10, 2'b10, 32'h1030, 13'h031);
    step(0, 0, 0, 1, 13'h040, 13'h032, 2'b10, 2'b10, 32'h1031, 13'h032);
    step(0, 0, 0, 0, 13'h040, 13'h033, 2'b00, 2'b10, 32'h1032, 13'h032);
    step(0, 0, 1, 1, 13'h040, 13'h033, 2'b10, 2'b00, 32'h0,    13'h033);
    step(0, 0, 1, 1, 13'h040, 13'h034, 2'b10, 2'b10, 32'h1033, 13'h034);
    step(0, 0, 1, 1, 13'h040, 13'h035, 2'b10, 2'b10, 32'h1034, 13'h035);
    step(0, 0, 1, 1, 13'h040, 13'h036, 2'b10, 2'b10, 32'h1035, 13'h036);
    step(0, 0, 1, 1, 13'h040, 13'h037, 2'b01, 2'b10, 32'h1036, 13'h040);
    step(0, 0, 0, 0, 13'h041, 13'h037, 2'b00, 2'b01, 32'h1040, 13'h040);

    // burst 1: strict alternation
    step(2, 1, 1, 1, 13'h050, 13'h060, 2'b00, 2'b00, 32'h0,    13'h000);
    step(2, 0, 1, 1, 13'h050, 13'h060, 2'b01, 2'b00, 32'h0,    13'h050);
    step(2, 0, 1, 1, 13'h051, 13'h060, 2'b10, 2'b01, 32'h1050, 13'h060);
    step(2, 0, 1, 1, 13'h051, 13'h061, 2'b01, 2'b10, 32'h1060, 13'h051);
    step(2, 0, 1, 1, 13'h052, 13'h061, 2'b10, 2'b01, 32'h1051, 13'h061);
    step(2, 0, 1, 1, 13'h052, 13'h062, 2'b01, 2'b10, 32'h1061, 13'h052);
    step(2, 0, 1, 1, 13'h053, 13'h062, 2'b10, 2'b01, 32'h1052, 13'h062);
    step(2, 0, 0, 0, 13'h053, 13'h063, 2'b00, 2'b10, 32'h1062, 13'h062);

    // idle resets run, latency 3
    step(1, 1, 1, 1, 13'h080, 13'h070, 2'b00, 2'b00, 32'h0,    13'h000);
    step(1, 0, 0, 1, 13'h080, 13'h070, 2'b10, 2'b00, 32'h0,    13'h070);
    step(1, 0, 0, 1, 13'h080, 13'h071, 2'b10, 2'b00, 32'h0,    13'h071);
    step(1, 0, 0, 1, 13'h080, 13'h072, 2'b10, 2'b00, 32'h0,    13'h072);
    step(1, 0, 0, 0, 13'h080, 13'h073, 2'b00, 2'b10, 32'h1070, 13'h072);
    step(1, 0, 1, 1, 13'h080, 13'h073, 2'b10, 2'b10, 32'h1071, 13'h073);
    step(1, 0, 1, 1, 13'h080, 13'h074, 2'b10, 2'b10, 32'h1072, 13'h074);
    step(1, 0, 1, 1, 13'h080, 13'h075, 2'b10, 2'b00, 32'h0,    13'h075);
    step(1, 0, 1, 1, 13'h080, 13'h076, 2'b10, 2'b10, 32'h1073, 13'h076);
    step(1, 0, 1, 1, 13'h080, 13'h077, 2'b01, 2'b10, 32'h1074, 13'h080);
    step(1, 0, 0, 0, 13'h081, 13'h077, 2'b00, 2'b10, 32'h1075, 13'h080);
    step(1, 0, 0, 0, 13'h081, 13'h077, 2'b00, 2'b10, 32'h1076, 13'h080);
    step(1, 0, 0, 0, 13'h081, 13'h077, 2'b00, 2'b01, 32'h1080, 13'h080);
    step(1, 0, 0, 0, 13'h081, 13'h077, 2'b00, 2'b00, 32'h0,    13'h080);

    // reset with two reads in flight, latency 3
    step(1, 0, 1, 0, 13'h090, 13'h077, 2'b01, 2'b00, 32'h0,    13'h090);
    step(1, 0, 1, 0, 13'h091, 13'h077, 2'b01, 2'b00, 32'h0,    13'h091);
    step(1, 1, 1, 0, 13'h092, 13'h077, 2'b00, 2'b00, 32'h0,    13'h000);
    step(1, 0, 0, 0, 13'h092, 13'h077, 2'b00, 2'b00, 32'h0,    13'h000);
    step(1, 0, 0, 0, 13'h092, 13'h077, 2'b00, 2'b00, 32'h0,    13'h000);
    step(1, 0, 1, 0, 13'h092, 13'h077, 2'b01, 2'b00, 32'h0,    13'h092);
    step(1, 0, 0, 0, 13'h093, 13'h077, 2'b00, 2'b00, 32'h0,    13'h092);
    step(1, 0, 0, 0, 13'h093, 13'h077, 2'b00, 2'b00, 32'h0,    13'h092);
    step(1, 0, 0, 0, 13'h093, 13'h077, 2'b00, 2'b01, 32'h1092, 13'h092);
    step(1, 0, 0, 0, 13'h093, 13'h077, 2'b00, 2'b00, 32'h0,    13'h092);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Two-requester arbiter sharing one read port of the 8K-word dual-port instruction memory: the second port of that memory is multiplexed between two readers, e.g. a debug/loader fetch and a secondary fetch stream. The block selects one requester per cycle, drives the shared memory address, and tracks every in-flight read through the memory's fixed read latency. It returns each data word only to the requester that issued it. It sits directly between the requesters and the memory port and contains no data storage beyond in-flight tags.

## Interface
- ADDR_WIDTH, 13: instruction word address width (8K words).
- READ_LATENCY, 1: cycles from address sample edge to valid mem_q; legal 1..3.
- MAX_BURST, 4: maximum consecutive grants to one requester while the other is requesting; legal 1..15.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 read request, level.
- addr0  in  ADDR_WIDTH  requester 0 word address, valid with req0.
- gnt0  out  1  requester 0 address accepted this cycle.
- rvalid0  out  1  rdata0 valid this cycle.
- rdata0  out  32  read data to requester 0.
- req1, addr1, gnt1, rvalid1, rdata1: same for requester 1.
- mem_addr  out  ADDR_WIDTH  address to shared memory port.
- mem_q  in  32  memory read data.

## Operation
- Arbitration state: last (granted id, 1 bit), run (consecutive-grant count, saturating at MAX_BURST).
- Grant rule each cycle:
  - neither req: no grant; run <= 0; last unchanged.
  - exactly one req: grant it.
  - both req: grant last if run < MAX_BURST, else grant the other.
- On grant to g: if g == last then run <= min(run+1, MAX_BURST), else run <= 1; last <= g.
- At most one of gnt0/gnt1 high in any cycle. A gnt never asserts without its req.
- mem_addr: combinational addr of granted requester in a grant cycle; otherwise a registered copy of the last granted address (0 after reset).
- In-flight tracking: a READ_LATENCY-deep shift register of {valid, id}; it receives {grant, g} every cycle.
- Response: the tail entry drives rvalid(id) = 1. rdata0 and rdata1 both carry mem_q continuously. Requesters sample only when their rvalid is high.
- Requesters may hold req across cycles. Each gnt consumes exactly one address, so a requester must advance its address after gnt. With no gnt, the address must stay stable.
- Reset, including mid-operation:
  - all in-flight entries cleared; no rvalid is produced for reads issued before reset.
  - gnt0/gnt1 forced 0 while rst is high.
  - last = 0, run = 0, mem_addr = 0, rvalid0 = rvalid1 = 0.

## Timing
- gnt is combinational from req and state, in the same cycle as the request. The address is sampled by the memory at the following rising edge.
- Grant in cycle T gives rvalid for that requester in cycle T+READ_LATENCY, with data = mem_q in that cycle.
- Throughput: one read per cycle sustained. Responses return in grant order.
- First contested cycle after reset: requester 0 wins (last = 0, run = 0).
- Simultaneous events: a grant and a response in the same cycle are independent. rvalid0 and rvalid1 are never both high.
- The first cycle after rst deasserts is arbitrated normally.

## Test plan
- Reset: hold rst 3 cycles with req0 = req1 = 1 -> gnt0 = gnt1 = rvalid0 = rvalid1 = 0 and mem_addr = 0 throughout.
- Single requester, READ_LATENCY = 1: req0 for 4 cycles, addr 0x000..0x003, memory preloaded with word = addr + 0x1000 -> gnt0 every cycle; rvalid0 on the next 4 cycles with rdata0 = 0x1000..0x1003; rvalid1 never high.
- Contention, MAX_BURST = 4: req0 and req1 held high from reset for 10 cycles -> grant sequence 0,0,0,0,1,1,1,1,0,0.
- MAX_BURST = 1 contention: both held 6 cycles -> strict alternation 0,1,0,1,0,1; each rvalid follows its gnt by READ_LATENCY with the correct data.
- Idle resets run (MAX_BURST = 4):
  - req1 alone for 3 grants, then 1 idle cycle, then both request -> requester 1 granted 4 more times before requester 0.
  - Repeat with READ_LATENCY = 3: responses return 3 cycles after each grant, in order.
- Reset mid-flight, READ_LATENCY = 3: grant req0 at cycles 5 and 6, assert rst at cycle 7 -> no rvalid0 at cycles 8 or 9; after release, new reads return normally.
